shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter N SHALL be: N, default 8, word width in bits (legal range 2..32).
REQ-002 Port clk SHALL be: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port ser_in SHALL be: ser_in  input  1  serial data bit.
REQ-005 Port ser_valid SHALL be: ser_valid  input  1  ser_in carries a bit this cycle.
REQ-006 Port dir SHALL be: dir  input  1  0 = LSB-first, 1 = MSB-first.
REQ-007 Port abort SHALL be: abort  input  1  synchronous discard of the partial word.
REQ-008 Port q_reg SHALL be: q_reg  output  N  assembled word, registered.
REQ-009 Port q_valid SHALL be: q_valid  output  1  q_reg holds an unconsumed word.
REQ-010 Port q_ready SHALL be: q_ready  input  1  consumer accepts q_reg this cycle.
REQ-011 Port overrun SHALL be: overrun  output  1  sticky, a completed word was dropped.
REQ-012 Port bit_cnt SHALL be: bit_cnt  output  $clog2(N+1)  bits accepted into the current word.

Function
REQ-013 Assembly FSM SHALL have states IDLE (bit_cnt=0) and SHIFT (bit_cnt 1..N-1).
REQ-014 IDLE->SHIFT SHALL occur on ser_valid; dir SHALL be latched on that first bit and held for the word.
REQ-015 Mid-word changes of dir SHALL be ignored.
REQ-016 LSB-first: each accepted bit SHALL enter at bit N-1 of the shifter, contents shifting right.
REQ-017 MSB-first: each accepted bit SHALL enter at bit 0 of the shifter, contents shifting left.
REQ-018 On the N-th accepted bit, the complete word (including that bit) SHALL be offered to the output register and the FSM SHALL return to IDLE with bit_cnt=0 in the same edge.
REQ-019 Output transfer SHALL occur when q_valid=0, or when q_valid=1 and q_ready=1 in that cycle; q_reg SHALL update and q_valid SHALL be 1 on the following cycle.
REQ-020 q_valid SHALL clear when q_valid=1 and q_ready=1 and no word completes that cycle.
REQ-021 If a word completes while q_valid=1 and q_ready=0, the new word SHALL be dropped, q_reg SHALL keep its value, and overrun SHALL set to 1.
REQ-022 overrun SHALL clear only on reset.
REQ-023 abort=1 SHALL force IDLE and bit_cnt=0 next cycle, discard the partial word, and leave q_reg, q_valid and overrun unchanged.
REQ-024 abort SHALL take priority over a simultaneous ser_valid, so that bit is discarded.
REQ-025 ser_valid=0 SHALL hold shifter, bit_cnt and state, with no timeout.
REQ-026 Latency from the N-th ser_valid edge to q_valid=1 SHALL be exactly 1 cycle.
REQ-027 Sustained input SHALL be accepted every cycle (back-to-back words) with no bubbles.

Reset
REQ-028 Asserting reset SHALL immediately force q_reg=0, q_valid=0, overrun=0, bit_cnt=0, shifter=0, state=IDLE and latched dir=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word; the first ser_valid after release SHALL be bit 0 of a new word.

Structure
REQ-030 Package shift_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and the direction enum (LSB_FIRST=0, MSB_FIRST=1).
REQ-031 Sub-module shift_bit_counter SHALL implement bit_cnt with inc, clear and wrap-at-N terminal flag; the shifter, output register and FSM SHALL remain in shift_deserializer.

Verification
REQ-032 Reset for 20 cycles, then release -> q_reg=0, q_valid=0, overrun=0, bit_cnt=0.
REQ-033 LSB-first, bits 1,0,1,0,1,0,1,0 on consecutive cycles with q_ready=1 -> q_reg=8'b01010101 with q_valid pulse one cycle after the 8th bit.
REQ-034 MSB-first, bits 0,0,0,0,1,1,1,1 -> q_reg=8'b00001111; 100 random bytes back-to-back -> every byte matches a golden model and overrun=0.
REQ-035 q_ready=0, two complete words 8'hA5 then 8'h3C -> q_reg stays 8'hA5 and overrun=1; then q_ready=1 -> q_valid falls and overrun stays 1.
REQ-036 Abort after 5 bits, then 8 bits of 8'hC3 -> q_reg=8'hC3; reset asserted after 3 bits -> bit_cnt=0 and no word emitted.
REQ-037 q_ready=1 in the same cycle a new word completes while q_valid=1 -> q_reg takes the new word and q_valid stays 1 without a gap.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the serial-to-parallel deserializer: assembly FSM states
// and the bit-order selection.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts bits accepted into the current word; tc flags the N-th bit so the
// counter wraps to zero on the same edge the word completes.
module shift_bit_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc  = inc && (cnt_q == CW'(N - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: assembles N-bit words LSB- or MSB-first
// into a registered output with a valid/ready hand-off and sticky overrun.
//
// state | meaning
// IDLE  | no bits of a word accepted yet (bit_cnt = 0)
// SHIFT | 1..N-1 bits of the current word accepted
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ser_in,
  input  logic                   ser_valid,
  input  logic                   dir,
  input  logic                   abort,
  output logic [N-1:0]           q_reg,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic                   overrun,
  output logic [$clog2(N+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  dir_e           dir_q, dir_d;
  dir_e           dir_eff;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   q_reg_q, q_reg_d;
  logic           q_valid_q, q_valid_d;
  logic           overrun_q, overrun_d;
  logic           accept;
  logic           cnt_tc;
  logic           word_done;

  // abort wins over a coincident bit, so that bit never reaches the counter
  assign accept = ser_valid && !abort;

  shift_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .clear (abort),
    .cnt   (bit_cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    shift_d   = shift_q;
    q_reg_d   = q_reg_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    word_done = 1'b0;
    dir_eff   = (state_q == IDLE) ? dir_e'(dir) : dir_q;

    if (abort) begin
      state_d = IDLE;
      shift_d = '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        dir_d = dir_e'(dir);
      end
      if (dir_eff == MSB_FIRST) begin
        shift_d = {shift_q[N-2:0], ser_in};
      end else begin
        shift_d = {ser_in, shift_q[N-1:1]};
      end
      state_d   = cnt_tc ? IDLE : SHIFT;
      word_done = cnt_tc;
    end

    // a completing word replaces the held one only if the consumer frees the slot
    if (word_done) begin
      if (!q_valid_q || q_ready) begin
        q_reg_d   = shift_d;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= LSB_FIRST;
      shift_q   <= '0;
      q_reg_q   <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      shift_q   <= shift_d;
      q_reg_q   <= q_reg_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign q_reg   = q_reg_q;
  assign q_valid = q_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (N=8): inputs change on the falling
// edge, outputs are compared on the falling edge after the active edge.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       dir = 1'b0;
  logic       abort = 1'b0;
  logic       q_ready = 1'b1;
  logic [7:0] q_reg;
  logic       q_valid;
  logic       overrun;
  logic [3:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  shift_deserializer #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .dir       (dir),
    .abort     (abort),
    .q_reg     (q_reg),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic d);
    @(negedge clk);
    ser_valid = 1'b1;
    ser_in    = b;
    dir       = d;
  endtask

  task automatic idle();
    @(negedge clk);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic d);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d ? w[7-i] : w[i], d);
    end
  endtask

  logic [7:0] w;
  logic [7:0] prev;
  logic       d;

  initial begin
    // reset held 20 cycles
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_q_reg", q_reg, 8'h00);
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_bit_cnt", bit_cnt, 4'd0);

    // LSB-first 1,0,1,0,1,0,1,0 -> 0x55, one-cycle valid pulse
    q_ready = 1'b1;
    send_word(8'h55, 1'b0);
    idle();
    check("lsb_q_reg", q_reg, 8'h55);
    check("lsb_q_valid", q_valid, 1'b1);
    check("lsb_bit_cnt", bit_cnt, 4'd0);
    idle();
    check("lsb_pulse_end", q_valid, 1'b0);

    // MSB-first 0,0,0,0 then pause (state held) then 1,1,1,1 -> 0x0F
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    idle();
    check("hold_bit_cnt_a", bit_cnt, 4'd4);
    idle();
    check("hold_bit_cnt_b", bit_cnt, 4'd4);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    idle();
    check("msb_q_reg", q_reg, 8'h0F);
    check("msb_q_valid", q_valid, 1'b1);

    // 100 random bytes back-to-back; dir wiggles mid-word and must be ignored
    prev = 8'h00;
    for (int k = 0; k < 100; k++) begin
      w = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0 && k > 0) begin
          check("rnd_q_reg", q_reg, prev);
          check("rnd_q_valid", q_valid, 1'b1);
        end
        ser_valid = 1'b1;
        ser_in    = d ? w[7-i] : w[i];
        dir       = (i == 0) ? d : 1'($urandom_range(0, 1));
      end
      prev = w;
    end
    idle();
    check("rnd_last_q_reg", q_reg, prev);
    check("rnd_overrun", overrun, 1'b0);
    idle();

    // overrun: A5 held, 3C dropped
    q_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    idle();
    check("ovr_first_q_reg", q_reg, 8'hA5);
    check("ovr_first_valid", q_valid, 1'b1);
    check("ovr_first_flag", overrun, 1'b0);
    send_word(8'h3C, 1'b0);
    idle();
    check("ovr_q_reg_kept", q_reg, 8'hA5);
    check("ovr_flag_set", overrun, 1'b1);
    q_ready = 1'b1;
    idle();
    check("ovr_valid_fall", q_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // abort after 5 bits, aborted cycle also carries a bit
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    @(negedge clk);
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    ser_valid = 1'b0;
    check("abort_bit_cnt", bit_cnt, 4'd0);
    check("abort_q_valid", q_valid, 1'b0);
    check("abort_overrun", overrun, 1'b1);
    check("abort_q_reg", q_reg, 8'h3C == 8'h3C ? 8'hA5 : 8'hA5);
    send_word(8'hC3, 1'b0);
    idle();
    check("post_abort_q_reg", q_reg, 8'hC3);
    check("post_abort_valid", q_valid, 1'b1);

    // new word completes with q_valid=1 and q_ready=1 -> replaced, no gap
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(w[0], 1'b0);
      ser_in = (8'h5A >> i) & 8'h01;
      if (i == 7) q_ready = 1'b1;
    end
    idle();
    q_ready = 1'b0;
    check("nogap_q_reg", q_reg, 8'h5A);
    check("nogap_q_valid", q_valid, 1'b1);
    idle();
    check("nogap_hold", q_valid, 1'b1);

    // reset mid-word
    q_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    @(negedge clk);
    ser_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("mrst_bit_cnt", bit_cnt, 4'd0);
    check("mrst_q_valid", q_valid, 1'b0);
    check("mrst_q_reg", q_reg, 8'h00);
    check("mrst_overrun", overrun, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    check("mrst_no_word", q_valid, 1'b0);
    send_word(8'h81, 1'b0);
    idle();
    check("mrst_new_word", q_reg, 8'h81);
    check("mrst_new_valid", q_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
